// File: rtl/mux_4_way_16_arbiter.sv
// Round-robin arbiter in front of the 4-way 16-bit mux: grants one of four
// valid/ready producers per cycle and registers the chosen word into a one-entry output stage.

module mux_4_way_16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    input  logic [15:0] i_d,
    input  logic [1:0]  i_sel,
    output logic [15:0] o_out
);

    always_comb begin
        o_out = i_a;
        case (i_sel)
            2'd0:    o_out = i_a;
            2'd1:    o_out = i_b;
            2'd2:    o_out = i_c;
            default: o_out = i_d;
        endcase
    end

endmodule

module mux_4_way_16_arbiter #(
    parameter int         WIDTH     = 16,
    parameter logic [1:0] RESET_PTR = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_src;

    logic [3:0]       w_rot;
    logic [1:0]       w_offset;
    logic [1:0]       w_grant;
    logic             w_load;
    logic             w_any;
    logic             w_ready_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_out;

    // w_rot[k] is the request k positions after the pointer, so the first
    // set bit of w_rot is the round-robin winner's distance from r_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFF = gi[1:0];
            assign w_rot[gi] = in_valid[r_ptr + OFF];
        end
    endgenerate

    always_comb begin
        w_offset = 2'd0;
        if (w_rot[0])      w_offset = 2'd0;
        else if (w_rot[1]) w_offset = 2'd1;
        else if (w_rot[2]) w_offset = 2'd2;
        else if (w_rot[3]) w_offset = 2'd3;
    end

    assign w_grant = r_ptr + w_offset;
    assign w_any   = |in_valid;
    assign w_load  = (r_state == ST_EMPTY) | out_ready;

    // Gating with rst_n keeps every ready low for the whole reset assertion,
    // not just until the first edge.
    assign w_ready_en = w_load & w_any & rst_n;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            localparam logic [1:0] CH = gi[1:0];
            assign in_ready[gi] = w_ready_en & (w_grant == CH);
        end
    endgenerate

    assign w_accept = |(in_valid & in_ready);
    assign select   = w_grant;

    mux_4_way_16 u_mux (
        .i_a   (in_a),
        .i_b   (in_b),
        .i_c   (in_c),
        .i_d   (in_d),
        .i_sel (w_grant),
        .o_out (w_mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= RESET_PTR;
            r_out   <= '0;
            r_src   <= 2'd0;
        end else begin
            if (w_accept) begin
                r_out <= w_mux_out;
                r_src <= w_grant;
                r_ptr <= w_grant + 2'd1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) r_state <= ST_FULL;
                end
                ST_FULL: begin
                    // Drain and refill in the same cycle stays FULL with no bubble.
                    if (!w_accept && out_ready) r_state <= ST_EMPTY;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out       = r_out;
    assign out_src   = r_src;
    assign out_valid = (r_state == ST_FULL);

endmodule
